// File: rtl/sample_player.sv
// ROM sample-playback engine: steps a ROM window at a programmable rate and
// hands formatted samples to the audio FIFO through a ready/write handshake.
module sample_player #(
  parameter int unsigned SAMPLE_W  = 6,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DIV_W     = 11,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned SIGNED_IN = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [DIV_W-1:0]    rate_div,
  input  logic [1:0]          chan_mode,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_channel_audio_out,
  output logic [OUT_W-1:0]    right_channel_audio_out,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [1:0] {StIdle, StPlay, StDrain} state_e;

  state_e              r_state, w_state_n;
  logic [ADDR_W-1:0]   r_rom_addr, w_addr_n;
  logic [ADDR_W-1:0]   r_start, w_start_n;
  logic [ADDR_W-1:0]   r_end, w_end_n;
  logic [DIV_W-1:0]    r_div, w_div_n;
  logic [DIV_W-1:0]    r_cnt, w_cnt_n;
  logic [SAMPLE_W-1:0] r_sample, w_sample_n;
  logic                r_pending, w_pending_n;
  logic                r_overrun, w_overrun_n;

  logic [DIV_W-1:0]    w_lat;
  logic [DIV_W-1:0]    w_eff_div;
  logic                w_tick;
  logic                w_write;
  logic [SAMPLE_W-1:0] w_msb;
  logic [SAMPLE_W-1:0] w_s;
  logic [OUT_W-1:0]    w_word;

  // Never tick faster than the ROM can return data for the current address.
  assign w_lat     = DIV_W'(ROM_LAT);
  assign w_eff_div = (rate_div < w_lat) ? w_lat : rate_div;

  assign w_tick  = (r_state == StPlay) && (r_cnt == r_div);
  // A stop in the same cycle kills the pending sample before it leaves.
  assign w_write = r_pending & audio_out_allowed & ~stop;

  assign w_msb  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  assign w_s    = (SIGNED_IN != 0) ? r_sample : (r_sample ^ w_msb);
  assign w_word = {w_s, {(OUT_W-SAMPLE_W){1'b0}}};

  always_comb begin
    w_state_n   = r_state;
    w_addr_n    = r_rom_addr;
    w_start_n   = r_start;
    w_end_n     = r_end;
    w_div_n     = r_div;
    w_cnt_n     = r_cnt;
    w_sample_n  = r_sample;
    w_pending_n = r_pending;
    w_overrun_n = r_overrun;
    if (stop) begin
      w_state_n   = StIdle;
      w_pending_n = 1'b0;
    end else if (start) begin
      w_start_n   = start_addr;
      w_end_n     = end_addr;
      w_div_n     = w_eff_div;
      w_addr_n    = start_addr;
      w_cnt_n     = '0;
      w_pending_n = 1'b0;
      w_overrun_n = 1'b0;
      w_state_n   = StPlay;
    end else begin
      if (w_write) begin
        w_pending_n = 1'b0;
      end
      case (r_state)
        StPlay: begin
          w_cnt_n = r_cnt + DIV_W'(1);
          if (w_tick) begin
            w_cnt_n     = '0;
            w_sample_n  = rom_q;
            w_pending_n = 1'b1;
            if (r_pending && !w_write) begin
              w_overrun_n = 1'b1;
            end
            if (r_rom_addr == r_end) begin
              if (loop_en) begin
                w_addr_n = r_start;
              end else begin
                w_state_n = StDrain;
              end
            end else begin
              w_addr_n = r_rom_addr + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (!r_pending || w_write) begin
            w_state_n = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rom_addr <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_sample   <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_rom_addr <= w_addr_n;
      r_start    <= w_start_n;
      r_end      <= w_end_n;
      r_div      <= w_div_n;
      r_cnt      <= w_cnt_n;
      r_sample   <= w_sample_n;
      r_pending  <= w_pending_n;
      r_overrun  <= w_overrun_n;
    end
  end

  assign rom_addr        = r_rom_addr;
  assign write_audio_out = w_write;
  assign busy            = (r_state != StIdle);
  assign overrun         = r_overrun;
  // Completion coincides with the last sample leaving; a restart or abort suppresses it.
  assign done = (r_state == StDrain) & (~r_pending | w_write) & ~stop & ~start;

  assign left_channel_audio_out =
      (w_write && (chan_mode == 2'b00 || chan_mode == 2'b10)) ? w_word : '0;
  assign right_channel_audio_out =
      (w_write && (chan_mode == 2'b01 || chan_mode == 2'b10)) ? w_word : '0;

endmodule

// File: tb/tb_sample_player.sv
// Randomised and directed bench for sample_player; writes are logged and
// compared against timings and data derived from address arithmetic.
module tb_sample_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, loop_en;
  logic [13:0] start_addr, end_addr, rom_addr;
  logic [10:0] rate_div;
  logic [1:0]  chan_mode;
  logic [5:0]  rom_q;
  logic        allowed, wr, busy, done, overrun;
  logic [31:0] left, right;

  logic [5:0]  rom [0:16383];
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  int          wc_q[$];
  logic [31:0] wl_q[$];
  logic [31:0] wr_q[$];
  int          done_q[$];

  sample_player dut (
    .CLOCK_50                (clk),
    .reset                   (rst),
    .start                   (start),
    .stop                    (stop),
    .loop_en                 (loop_en),
    .start_addr              (start_addr),
    .end_addr                (end_addr),
    .rate_div                (rate_div),
    .chan_mode               (chan_mode),
    .rom_addr                (rom_addr),
    .rom_q                   (rom_q),
    .audio_out_allowed       (allowed),
    .write_audio_out         (wr),
    .left_channel_audio_out  (left),
    .right_channel_audio_out (right),
    .busy                    (busy),
    .done                    (done),
    .overrun                 (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q <= rom[rom_addr];
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (wr) begin
      wc_q.push_back(cyc);
      wl_q.push_back(left);
      wr_q.push_back(right);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_logs();
    wc_q.delete();
    wl_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  // Offset-binary sample -> left-justified two's complement word.
  function automatic logic [31:0] fmt(input logic [5:0] d);
    logic [31:0] v;
    v = 32'(d ^ 6'd32);
    return v << 26;
  endfunction

  function automatic logic [31:0] exp_l(input int mode, input logic [31:0] w);
    return (mode == 0 || mode == 2) ? w : 32'd0;
  endfunction

  function automatic logic [31:0] exp_r(input int mode, input logic [31:0] w);
    return (mode == 1 || mode == 2) ? w : 32'd0;
  endfunction

  task automatic kick(input int sa, input int ea, input int rd, input int mode,
                      output int cs);
    start_addr = 14'(sa);
    end_addr   = 14'(ea);
    rate_div   = 11'(rd);
    chan_mode  = 2'(mode);
    start      = 1'b1;
    cs         = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic run_oneshot(input int sa, input int len, input int rd, input int mode);
    int cs, eff, ea, n, a;
    clear_logs();
    ea      = (sa + len - 1) % 16384;
    loop_en = 1'b0;
    allowed = 1'b1;
    kick(sa, ea, rd, mode, cs);
    eff = (rd < 1) ? 1 : rd;
    repeat (len * (eff + 1) + 6) step();
    check("oneshot_nwrites", 64'(wc_q.size()), 64'(len));
    n = (wc_q.size() < len) ? wc_q.size() : len;
    for (int k = 0; k < n; k++) begin
      a = (sa + k) % 16384;
      check("oneshot_wr_cycle", 64'(wc_q[k]), 64'(cs + (k + 1) * (eff + 1) + 1));
      check("oneshot_left", 64'(wl_q[k]), 64'(exp_l(mode, fmt(rom[a]))));
      check("oneshot_right", 64'(wr_q[k]), 64'(exp_r(mode, fmt(rom[a]))));
    end
    check("oneshot_done_cnt", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0 && n > 0) check("oneshot_done_cyc", 64'(done_q[0]), 64'(wc_q[n-1]));
    check("oneshot_busy", 64'(busy), 64'd0);
    check("oneshot_rom_addr", 64'(rom_addr), 64'(ea));
  endtask

  initial begin
    int cs, cs2, a;
    for (int i = 0; i < 16384; i++) rom[i] = 6'($urandom);
    for (int i = 0; i < 4; i++) rom[i] = 6'(i);
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; allowed = 1'b1;
    start_addr = '0; end_addr = '0; rate_div = '0; chan_mode = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_left", 64'(left), 64'd0);
    check("rst_right", 64'(right), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Directed one-shot, clamp, channel modes
    run_oneshot(0, 4, 4, 0);
    check("basic_w0", 64'(wl_q.size() > 0 ? wl_q[0] : 32'd1), 64'h8000_0000);
    check("basic_w3", 64'(wl_q.size() > 3 ? wl_q[3] : 32'd1), 64'h8C00_0000);
    run_oneshot(200, 4, 0, 0);
    run_oneshot(1000, 3, 2, 1);
    run_oneshot(1100, 3, 3, 2);
    run_oneshot(1200, 2, 1, 3);
    for (int t = 0; t < 8; t++)
      run_oneshot(int'($urandom_range(0, 16383)), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

    // Loop across the address wrap, then leave loop mode
    rom[16382] = 6'd10; rom[16383] = 6'd20; rom[0] = 6'd30; rom[1] = 6'd40;
    clear_logs();
    loop_en = 1'b1;
    allowed = 1'b1;
    kick(16382, 1, 2, 0, cs);
    for (int i = 0; i < 100 && wc_q.size() < 6; i++) step();
    check("loop_reach6", 64'(wc_q.size() >= 6), 64'd1);
    check("loop_no_done", 64'(done_q.size()), 64'd0);
    loop_en = 1'b0;
    repeat (40) step();
    check("loop_nwrites", 64'(wc_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < wc_q.size(); k++) begin
      a = (16382 + (k % 4)) % 16384;
      check("loop_data", 64'(wl_q[k]), 64'(fmt(rom[a])));
      check("loop_cycle", 64'(wc_q[k]), 64'(cs + (k + 1) * 3 + 1));
    end
    check("loop_done_cnt", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0 && wc_q.size() > 0)
      check("loop_done_cyc", 64'(done_q[0]), 64'(wc_q[wc_q.size()-1]));
    check("loop_busy", 64'(busy), 64'd0);

    // Long backpressure: second tick overwrites the first
    clear_logs();
    allowed = 1'b0;
    kick(300, 310, 4, 0, cs);
    wait_to(cs + 13);
    allowed = 1'b1;
    wait_to(cs + 18);
    check("bp_nwrites", 64'(wc_q.size()), 64'd2);
    if (wc_q.size() >= 2) begin
      check("bp_w0_cyc", 64'(wc_q[0]), 64'(cs + 13));
      check("bp_w0_data", 64'(wl_q[0]), 64'(fmt(rom[301])));
      check("bp_w1_cyc", 64'(wc_q[1]), 64'(cs + 16));
      check("bp_w1_data", 64'(wl_q[1]), 64'(fmt(rom[302])));
    end
    check("bp_overrun", 64'(overrun), 64'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check("bp_stop_busy", 64'(busy), 64'd0);

    // Short backpressure inside one period: late write, no overrun
    clear_logs();
    allowed = 1'b0;
    kick(400, 410, 4, 0, cs);
    wait_to(cs + 8);
    allowed = 1'b1;
    wait_to(cs + 13);
    check("bps_nwrites", 64'(wc_q.size()), 64'd2);
    if (wc_q.size() >= 2) begin
      check("bps_w0_cyc", 64'(wc_q[0]), 64'(cs + 8));
      check("bps_w0_data", 64'(wl_q[0]), 64'(fmt(rom[400])));
      check("bps_w1_cyc", 64'(wc_q[1]), 64'(cs + 11));
    end
    check("bps_overrun", 64'(overrun), 64'd0);
    stop = 1'b1; step(); stop = 1'b0;

    // Stop with a sample pending
    clear_logs();
    allowed = 1'b0;
    kick(500, 510, 4, 0, cs);
    wait_to(cs + 7);
    stop = 1'b1;
    allowed = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_wr", 64'(wr), 64'd0);
    repeat (15) step();
    check("stop_nwrites", 64'(wc_q.size()), 64'd0);
    check("stop_no_done", 64'(done_q.size()), 64'd0);

    // Simultaneous start and stop
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", 64'(busy), 64'd0);
    repeat (10) step();
    check("startstop_nwrites", 64'(wc_q.size()), 64'd0);

    // Restart during PLAY clears overrun and uses the new window
    allowed = 1'b0;
    kick(600, 620, 4, 0, cs);
    wait_to(cs + 12);
    check("restart_pre_ovr", 64'(overrun), 64'd1);
    clear_logs();
    kick(700, 703, 4, 0, cs2);
    allowed = 1'b1;
    check("restart_ovr_clr", 64'(overrun), 64'd0);
    check("restart_addr", 64'(rom_addr), 64'd700);
    repeat (30) step();
    check("restart_nwrites", 64'(wc_q.size()), 64'd4);
    if (wc_q.size() > 0) begin
      check("restart_w0_cyc", 64'(wc_q[0]), 64'(cs2 + 6));
      check("restart_w0_data", 64'(wl_q[0]), 64'(fmt(rom[700])));
    end
    check("restart_done", 64'(done_q.size()), 64'd1);

    // Reset mid-play
    allowed = 1'b1;
    kick(800, 815, 1, 2, cs);
    repeat (7) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_wr", 64'(wr), 64'd0);
    check("midrst_left", 64'(left), 64'd0);
    check("midrst_right", 64'(right), 64'd0);
    check("midrst_rom_addr", 64'(rom_addr), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
